// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between instruction fetch and load/store
module mem_port_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ireq_i,
   input  logic [ADDR_WIDTH-1:0] iaddr_i,
   output logic [DATA_WIDTH-1:0] irdata_o,
   output logic                  iready_o,
   input  logic                  dreq_i,
   input  logic                  dwe_i,
   input  logic [ADDR_WIDTH-1:0] daddr_i,
   input  logic [DATA_WIDTH-1:0] dwdata_i,
   input  logic [2:0]            dfunct3_i,
   output logic [DATA_WIDTH-1:0] drdata_o,
   output logic                  dready_o,
   output logic                  mreq_o,
   output logic                  mwe_o,
   output logic [ADDR_WIDTH-1:0] maddr_o,
   output logic [DATA_WIDTH-1:0] mwdata_o,
   output logic [2:0]            mfunct3_o,
   input  logic                  mack_i,
   input  logic [DATA_WIDTH-1:0] mrdata_i,
   output logic                  grant_o
);
   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t                state_q, state_d;
   logic [SW-1:0]         streak_q, streak_d;
   logic                  grant_q, grant_d;
   logic                  mreq_q, mreq_d;
   logic                  mwe_q, mwe_d;
   logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;
   logic [2:0]            mfunct3_q, mfunct3_d;
   logic [DATA_WIDTH-1:0] irdata_q, irdata_d;
   logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
   logic                  iready_q, iready_d;
   logic                  dready_q, dready_d;
   logic                  any_req, streak_full, pick_data, grant_now, ack;
   // Arbitration: data wins unless fetch has already lost MAX_DATA_STREAK contested rounds
   always_comb begin
      any_req     = ireq_i | dreq_i;
      streak_full = (streak_q == SW'(MAX_DATA_STREAK));
      pick_data   = dreq_i & ~(ireq_i & streak_full);
      grant_now   = (state_q == IDLE) & any_req;
      ack         = (state_q == BUSY) & mack_i;
   end
   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end
   // Next-state: grant in IDLE, wait for ack in BUSY, one response cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = any_req ? BUSY : IDLE;
         BUSY:    state_d = mack_i ? RESP : BUSY;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // Output/datapath next values: latch the winner's payload on grant, capture read data on ack
   always_comb begin
      streak_d  = streak_q;
      grant_d   = grant_q;
      mwe_d     = mwe_q;
      maddr_d   = maddr_q;
      mwdata_d  = mwdata_q;
      mfunct3_d = mfunct3_q;
      if (grant_now) begin
         grant_d   = pick_data;
         mwe_d     = pick_data & dwe_i;
         maddr_d   = pick_data ? daddr_i : iaddr_i;
         mwdata_d  = pick_data ? dwdata_i : '0;
         mfunct3_d = pick_data ? dfunct3_i : 3'b010;
         streak_d  = (pick_data & ireq_i) ? (streak_full ? streak_q : streak_q + SW'(1)) : '0;
      end
      mreq_d   = (state_d == BUSY);
      iready_d = ack & ~grant_q;
      dready_d = ack & grant_q;
      irdata_d = (ack & ~grant_q) ? mrdata_i : irdata_q;
      drdata_d = (ack & grant_q & ~mwe_q) ? mrdata_i : drdata_q;
   end
   // Output/datapath registers; reset abandons any transaction in flight
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         streak_q  <= '0;
         grant_q   <= 1'b0;
         mreq_q    <= 1'b0;
         mwe_q     <= 1'b0;
         maddr_q   <= '0;
         mwdata_q  <= '0;
         mfunct3_q <= '0;
         irdata_q  <= '0;
         drdata_q  <= '0;
         iready_q  <= 1'b0;
         dready_q  <= 1'b0;
      end else begin
         streak_q  <= streak_d;
         grant_q   <= grant_d;
         mreq_q    <= mreq_d;
         mwe_q     <= mwe_d;
         maddr_q   <= maddr_d;
         mwdata_q  <= mwdata_d;
         mfunct3_q <= mfunct3_d;
         irdata_q  <= irdata_d;
         drdata_q  <= drdata_d;
         iready_q  <= iready_d;
         dready_q  <= dready_d;
      end
   end
   assign grant_o   = grant_q;
   assign mreq_o    = mreq_q;
   assign mwe_o     = mwe_q;
   assign maddr_o   = maddr_q;
   assign mwdata_o  = mwdata_q;
   assign mfunct3_o = mfunct3_q;
   assign irdata_o  = irdata_q;
   assign drdata_o  = drdata_q;
   assign iready_o  = iready_q;
   assign dready_o  = dready_q;
endmodule
